// File: rtl/lockin_fifo_down_sequencer.sv
// Serialises 64-bit lock-in results from NUM_REQ producers into 32-bit Avalon-ST words.
// Each frame carries one result per producer in index order, low word first.
module lockin_fifo_down_sequencer #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       frame_count,
    input  logic [64*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            src_data,
    output logic                   src_valid,
    input  logic                   src_ready,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sent_frames
);

    localparam int unsigned CH_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StSendLo,
        StSendHi,
        StDone
    } state_e;

    state_e           state_q;
    logic [CH_W-1:0]  ch_q;
    logic [CNT_W-1:0] sent_q;
    logic [CNT_W-1:0] limit_q;
    logic [63:0]      data_q;

    logic stop_now;
    logic limit_hit;
    logic accept;

    // Stopping is only honoured on a frame boundary so the word stream stays aligned.
    assign stop_now  = !enable && (ch_q == '0);
    assign limit_hit = (limit_q != '0) && (sent_q == limit_q);
    assign accept    = (state_q == StWait) && !stop_now && !limit_hit && req_valid[ch_q];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[ch_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ch_q    <= '0;
            sent_q  <= '0;
            limit_q <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        limit_q <= frame_count;
                        sent_q  <= '0;
                        ch_q    <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (stop_now) begin
                        state_q <= StIdle;
                    end else if (limit_hit) begin
                        state_q <= StDone;
                    end else if (req_valid[ch_q]) begin
                        data_q  <= req_data[64*int'(ch_q) +: 64];
                        state_q <= StSendLo;
                    end
                end
                StSendLo: begin
                    if (src_ready) begin
                        state_q <= StSendHi;
                    end
                end
                StSendHi: begin
                    if (src_ready) begin
                        if (ch_q == LAST_CH) begin
                            ch_q <= '0;
                            if (sent_q != '1) begin
                                sent_q <= sent_q + 1'b1;
                            end
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                        state_q <= StWait;
                    end
                end
                StDone: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Source outputs decode straight from registered state, so they hold steady under stall.
    assign src_valid = (state_q == StSendLo) || (state_q == StSendHi);

    always_comb begin
        src_data = '0;
        if (state_q == StSendLo) begin
            src_data = data_q[31:0];
        end else if (state_q == StSendHi) begin
            src_data = data_q[63:32];
        end
    end

    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign done        = (state_q == StDone);
    assign sent_frames = sent_q;

endmodule

// File: tb/tb_lockin_fifo_down_sequencer.sv
// Scoreboard bench: expected words are queued as stimulus is set up and popped on each beat.
module tb_lockin_fifo_down_sequencer;

    localparam int unsigned NR = 2;
    localparam int unsigned CW = 2;

    localparam logic [63:0] RES0 = 64'h11112222_33334444;
    localparam logic [63:0] RES1 = 64'hAAAABBBB_CCCCDDDD;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [CW-1:0]     frame_count = '0;
    logic [64*NR-1:0]  req_data = {RES1, RES0};
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [31:0]       src_data;
    logic              src_valid;
    logic              src_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [CW-1:0]     sent_frames;

    lockin_fifo_down_sequencer #(
        .NUM_REQ (NR),
        .CNT_W   (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_count (frame_count),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .busy        (busy),
        .done        (done),
        .sent_frames (sent_frames)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int          word_cnt = 0;
    int          rdy0_cnt = 0;
    int          rdy1_cnt = 0;
    int          rdy1_at_word = 0;

    // Inputs only change #1 after posedge, so a beat seen here completes at the next posedge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (src_valid && src_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_unexpected: got %h, no word expected", src_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (src_data !== exp_w) begin
                        fails++;
                        $display("FAIL word_order: got %h, want %h", src_data, exp_w);
                    end
                end
                word_cnt++;
            end
            if (req_ready[0]) rdy0_cnt++;
            if (req_ready[1]) begin
                rdy1_cnt++;
                rdy1_at_word = word_cnt;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++) begin
            exp_q.push_back(RES0[31:0]);
            exp_q.push_back(RES0[63:32]);
            exp_q.push_back(RES1[31:0]);
            exp_q.push_back(RES1[63:32]);
        end
    endtask

    task automatic wait_words(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (word_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        step(3);
        tests++;
        if ({src_valid, req_ready, busy, done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got v=%b rr=%b busy=%b done=%b, want all 0",
                     src_valid, req_ready, busy, done);
        end
        tests++;
        if (src_data !== 32'h0 || sent_frames !== '0) begin
            fails++;
            $display("FAIL reset_data: got data=%h sent=%0d, want 0/0", src_data, sent_frames);
        end
        reset_n = 1'b1;
        step(2);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_frames();
        int cyc;
        int r0;
        int r1;
        r0 = rdy0_cnt;
        r1 = rdy1_cnt;
        frame_count = 2'd2;
        src_ready = 1'b1;
        req_valid = 2'b11;
        push_frames(2);
        enable = 1'b1;
        step(1);
        cyc = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (busy) cyc++;
            step(1);
        end
        // 12 streaming cycles plus the WAIT cycle that detects the frame limit.
        tests++;
        if (cyc != 13) begin
            fails++;
            $display("FAIL frames_cycles: got %0d busy cycles, want 13", cyc);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || src_valid !== 1'b0) begin
            fails++;
            $display("FAIL frames_done: got done=%b busy=%b v=%b, want 1/0/0", done, busy, src_valid);
        end
        tests++;
        if (sent_frames !== 2'd2) begin
            fails++;
            $display("FAIL frames_sent: got %0d, want 2", sent_frames);
        end
        tests++;
        if ((rdy0_cnt - r0) != 2 || (rdy1_cnt - r1) != 2) begin
            fails++;
            $display("FAIL frames_pulses: got %0d/%0d, want 2/2", rdy0_cnt - r0, rdy1_cnt - r1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL frames_left: got %0d words pending, want 0", exp_q.size());
        end
        step(3);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_hold: got %b, want 1", done);
        end
        enable = 1'b0;
        step(2);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_exit: got %b, want 0", done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        frame_count = 2'd1;
        src_ready = 1'b0;
        req_valid = 2'b11;
        push_frames(1);
        enable = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (src_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        tests++;
        if (!ok || src_data !== RES0[31:0]) begin
            fails++;
            $display("FAIL bp_lo: got ok=%b data=%h, want 1/%h", ok, src_data, RES0[31:0]);
        end
        src_ready = 1'b1;
        step(1);
        src_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (src_valid !== 1'b1 || src_data !== RES0[63:32]) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d got v=%b data=%h, want 1/%h",
                         k, src_valid, src_data, RES0[63:32]);
            end
            step(1);
        end
        src_ready = 1'b1;
        step(1);
        tests++;
        if (src_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got v=%b, want 0", src_valid);
        end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        tests++;
        if (!ok || sent_frames !== 2'd1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bp_end: got done=%b sent=%0d pending=%0d, want 1/1/0",
                     ok, sent_frames, exp_q.size());
        end
        enable = 1'b0;
        step(2);
    endtask

    task automatic test_ordering();
        bit ok;
        int w0;
        w0 = word_cnt;
        frame_count = 2'd1;
        src_ready = 1'b1;
        req_valid = 2'b10;
        push_frames(1);
        enable = 1'b1;
        step(1);
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (req_ready !== 2'b00 || src_valid !== 1'b0) begin
                fails++;
                $display("FAIL ord_wait: cycle %0d got rr=%b v=%b, want 00/0", k, req_ready, src_valid);
            end
            step(1);
        end
        req_valid = 2'b11;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        tests++;
        if (!ok || exp_q.size() != 0) begin
            fails++;
            $display("FAIL ord_end: got done=%b pending=%0d, want 1/0", ok, exp_q.size());
        end
        tests++;
        if (rdy1_at_word != w0 + 2) begin
            fails++;
            $display("FAIL ord_ch1_accept: got after %0d words, want %0d", rdy1_at_word - w0, 2);
        end
        enable = 1'b0;
        step(2);
    endtask

    task automatic test_stop_mid();
        bit ok;
        int w0;
        w0 = word_cnt;
        frame_count = 2'd0;
        src_ready = 1'b1;
        req_valid = 2'b11;
        push_frames(3);
        enable = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (sent_frames == 2'd2 && src_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        enable = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || sent_frames !== 2'd3 || done !== 1'b0) begin
            fails++;
            $display("FAIL stop_state: got idle=%b sent=%0d done=%b, want 1/3/0", ok, sent_frames, done);
        end
        tests++;
        if (word_cnt - w0 != 12 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stop_words: got %0d words, want 12", word_cnt - w0);
        end
        step(2);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int w0;
        frame_count = 2'd0;
        src_ready = 1'b1;
        req_valid = 2'b11;
        push_frames(2);
        enable = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (sent_frames == 2'd2 && src_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        src_ready = 1'b0;
        tests++;
        if (!ok || src_data !== RES0[31:0]) begin
            fails++;
            $display("FAIL rst_mid_setup: got ok=%b data=%h, want 1/%h", ok, src_data, RES0[31:0]);
        end
        reset_n = 1'b0;
        step(1);
        tests++;
        if (src_valid !== 1'b0 || req_ready !== 2'b00 || sent_frames !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: got v=%b rr=%b sent=%0d busy=%b, want 0/00/0/0",
                     src_valid, req_ready, sent_frames, busy);
        end
        w0 = word_cnt;
        push_frames(1);
        src_ready = 1'b1;
        reset_n = 1'b1;
        wait_words(w0 + 4, ok);
        enable = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_restart: got %0d words, want 4", word_cnt - w0);
        end
        wait_idle(ok);
        tests++;
        if (!ok || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rst_restart_end: got idle=%b pending=%0d, want 1/0", ok, exp_q.size());
        end
        step(2);
    endtask

    task automatic test_saturation();
        bit ok;
        int w0;
        logic [CW-1:0] want;
        w0 = word_cnt;
        frame_count = 2'd0;
        src_ready = 1'b1;
        req_valid = 2'b11;
        push_frames(5);
        enable = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            wait_words(w0 + 4 * f, ok);
            want = (f > 3) ? 2'd3 : CW'(f);
            tests++;
            if (!ok || sent_frames !== want || done !== 1'b0) begin
                fails++;
                $display("FAIL sat_frame%0d: got ok=%b sent=%0d done=%b, want 1/%0d/0",
                         f, ok, sent_frames, done, want);
            end
        end
        enable = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || exp_q.size() != 0) begin
            fails++;
            $display("FAIL sat_end: got idle=%b pending=%0d, want 1/0", ok, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_backpressure();
        test_ordering();
        test_stop_mid();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
